uart_tx_arbiter: RTL and testbench

- Shares one uart_tx serializer between NUM_REQ byte producers (debug console, status reporter, echo path, ...).
- Round-robin arbitration per byte; a multi-byte message can hold the grant until its last byte so messages never interleave.
- Sits between requesters and uart_tx: drives uart_tx i_write/i_data, observes uart_tx o_busy.

---
 rtl/uart_tx_arbiter.sv | 170 +++++++++++++++++
 tb/tb_uart_tx_arbiter.sv | 289 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/uart_tx_arbiter.sv
// Round-robin arbiter that shares one uart_tx serializer between NUM_REQ byte producers.
// Optional forced unlock of a stalled message owner: define UART_ARB_TIMEOUT_EN.
module uart_tx_arbiter #(
  parameter int NUM_REQ      = 4,
  parameter int LOCK_TIMEOUT = 1024
) (
  input  logic                 i_clk,
  input  logic                 i_rst,
  input  logic [NUM_REQ-1:0]   i_req_valid,
  input  logic [8*NUM_REQ-1:0] i_req_data,
  input  logic [NUM_REQ-1:0]   i_req_last,
  output logic [NUM_REQ-1:0]   o_req_ready,
  output logic [NUM_REQ-1:0]   o_grant,
  output logic                 o_locked,
  output logic                 o_tx_write,
  output logic [7:0]           o_tx_data,
  input  logic                 i_tx_busy
`ifdef UART_ARB_TIMEOUT_EN
  ,
  output logic                 o_lock_timeout
`endif
);

  localparam int PTR_W = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;

  typedef enum logic [1:0] {
    IDLE,
    WAIT_START,
    WAIT_DONE
  } state_t;

  state_t             state_q, state_d;
  logic [PTR_W-1:0]   ptr_q, ptr_d;
  logic [PTR_W-1:0]   owner_q, owner_d;
  logic               locked_q, locked_d;
  logic [NUM_REQ-1:0] grant_q, grant_d;
  logic [NUM_REQ-1:0] ready_q, ready_d;
  logic               write_q, write_d;
  logic [7:0]         data_q, data_d;
  logic               sel_found;
  logic [PTR_W-1:0]   sel_idx;
  int                 scan_idx;

  function automatic logic [PTR_W-1:0] next_idx(input logic [PTR_W-1:0] k);
    if (int'(k) == NUM_REQ - 1) return '0;
    return k + 1'b1;
  endfunction

  // While locked only the owner may be picked; otherwise scan ptr, ptr+1, ... with wrap.
  always_comb begin
    // NOTE: every always_comb output gets a default first, so no latch is inferred.
    sel_found = 1'b0;
    sel_idx   = '0;
    scan_idx  = 0;
    if (locked_q) begin
      sel_found = i_req_valid[owner_q];
      sel_idx   = owner_q;
    end else begin
      // Descending offsets so the nearest valid requester after ptr is assigned last.
      for (int i = NUM_REQ - 1; i >= 0; i--) begin
        scan_idx = (int'(ptr_q) + i) % NUM_REQ;
        if (i_req_valid[scan_idx]) begin
          sel_found = 1'b1;
          sel_idx   = PTR_W'(scan_idx);
        end
      end
    end
  end

`ifdef UART_ARB_TIMEOUT_EN
  localparam int CNT_W = $clog2(LOCK_TIMEOUT + 1);
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             timeout_q, timeout_d;
  assign o_lock_timeout = timeout_q;
`else
  logic unused_lock_timeout;
  assign unused_lock_timeout = (LOCK_TIMEOUT > 0);
`endif

  always_comb begin
    state_d  = state_q;
    ptr_d    = ptr_q;
    owner_d  = owner_q;
    locked_d = locked_q;
    grant_d  = grant_q;
    ready_d  = '0;
    write_d  = 1'b0;
    data_d   = data_q;
`ifdef UART_ARB_TIMEOUT_EN
    cnt_d     = cnt_q;
    timeout_d = 1'b0;
`endif
    unique case (state_q)
      IDLE: begin
        if (!i_tx_busy && sel_found) begin
          state_d          = WAIT_START;
          data_d           = i_req_data[8*int'(sel_idx) +: 8];
          write_d          = 1'b1;
          ready_d[sel_idx] = 1'b1;
          grant_d          = '0;
          grant_d[sel_idx] = 1'b1;
          if (i_req_last[sel_idx]) begin
            locked_d = 1'b0;
            ptr_d    = next_idx(sel_idx);
          end else begin
            locked_d = 1'b1;
            owner_d  = sel_idx;
          end
`ifdef UART_ARB_TIMEOUT_EN
          cnt_d = '0;
`endif
        end
`ifdef UART_ARB_TIMEOUT_EN
        else if (locked_q && !i_req_valid[owner_q]) begin
          if (cnt_q == CNT_W'(LOCK_TIMEOUT - 1)) begin
            cnt_d     = '0;
            timeout_d = 1'b1;
            locked_d  = 1'b0;
            ptr_d     = next_idx(owner_q);
          end else begin
            cnt_d = cnt_q + 1'b1;
          end
        end
`endif
      end
      WAIT_START: if (i_tx_busy) state_d = WAIT_DONE;
      WAIT_DONE:  if (!i_tx_busy) state_d = IDLE;
      default:    state_d = IDLE;
    endcase
  end

  // Asynchronous reset clears arbiter state only; a byte already in uart_tx finishes on its own.
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      // NOTE: sequential state uses non-blocking assignments only.
      state_q  <= IDLE;
      ptr_q    <= '0;
      owner_q  <= '0;
      locked_q <= 1'b0;
      grant_q  <= '0;
      ready_q  <= '0;
      write_q  <= 1'b0;
      data_q   <= '0;
`ifdef UART_ARB_TIMEOUT_EN
      cnt_q     <= '0;
      timeout_q <= 1'b0;
`endif
    end else begin
      state_q  <= state_d;
      ptr_q    <= ptr_d;
      owner_q  <= owner_d;
      locked_q <= locked_d;
      grant_q  <= grant_d;
      ready_q  <= ready_d;
      write_q  <= write_d;
      data_q   <= data_d;
`ifdef UART_ARB_TIMEOUT_EN
      cnt_q     <= cnt_d;
      timeout_q <= timeout_d;
`endif
    end
  end

  assign o_req_ready = ready_q;
  assign o_grant     = grant_q;
  assign o_locked    = locked_q;
  assign o_tx_write  = write_q;
  assign o_tx_data   = data_q;

endmodule

// File: tb/tb_uart_tx_arbiter.sv
// Directed self-checking bench for uart_tx_arbiter (NUM_REQ=3) with a small uart_tx busy model.
// Define UART_ARB_TIMEOUT_EN to also exercise the forced-unlock path (LOCK_TIMEOUT=8).
module tb_uart_tx_arbiter;

  localparam int N     = 3;
  localparam int FRAME = 4;

  logic           clk = 1'b0;
  logic           rst = 1'b0;
  logic [N-1:0]   req_valid = '0;
  logic [8*N-1:0] req_data = '0;
  logic [N-1:0]   req_last = '0;
  logic [N-1:0]   req_ready;
  logic [N-1:0]   grant;
  logic           locked;
  logic           tx_write;
  logic [7:0]     tx_data;
  logic           tx_busy;
  logic           busy_hold = 1'b0;
  int             busy_cnt = 0;
  int             checks = 0;
  int             failures = 0;
  int             proto_err = 0;
  logic           prev_write = 1'b0;
`ifdef UART_ARB_TIMEOUT_EN
  logic           lock_timeout;
`endif

  uart_tx_arbiter #(.NUM_REQ(N), .LOCK_TIMEOUT(8)) dut (
    .i_clk       (clk),
    .i_rst       (rst),
    .i_req_valid (req_valid),
    .i_req_data  (req_data),
    .i_req_last  (req_last),
    .o_req_ready (req_ready),
    .o_grant     (grant),
    .o_locked    (locked),
    .o_tx_write  (tx_write),
    .o_tx_data   (tx_data),
    .i_tx_busy   (tx_busy)
`ifdef UART_ARB_TIMEOUT_EN
    ,
    .o_lock_timeout (lock_timeout)
`endif
  );

  always #5 clk = ~clk;

  // uart_tx stand-in: busy from the cycle after a write for FRAME cycles; ignores arbiter reset.
  always @(posedge clk) begin
    if (tx_write) busy_cnt <= FRAME;
    else if (busy_cnt > 0) busy_cnt <= busy_cnt - 1;
  end
  assign tx_busy = busy_hold || (busy_cnt != 0);

  // Protocol monitor: single-cycle strobes, no write into a busy uart, ready mirrors grant.
  always @(negedge clk) begin
    if (tx_write && prev_write) proto_err++;
    if (tx_write && tx_busy) proto_err++;
    if (req_ready != (tx_write ? grant : '0)) proto_err++;
    prev_write = tx_write;
  end

  task automatic wait_write(output bit seen);
    seen = 1'b0;
    for (int i = 0; i < 100; i++) begin
      @(negedge clk);
      if (tx_write) begin
        seen = 1'b1;
        return;
      end
    end
  endtask

  task automatic wait_quiet();
    int q = 0;
    for (int i = 0; i < 100 && q < 3; i++) begin
      @(negedge clk);
      q = tx_busy ? 0 : q + 1;
    end
  endtask

  task automatic expect_write(input string name, input logic [7:0] d, input logic [N-1:0] g,
                              input logic lk);
    bit seen;
    wait_write(seen);
    checks++;
    if (!seen) begin
      failures++;
      $display("FAIL %s: no o_tx_write within 100 cycles, expected data %h", name, d);
    end
    checks++;
    if ({tx_data, grant, locked} !== {d, g, lk}) begin
      failures++;
      $display("FAIL %s: data/grant/locked got %h/%b/%b expected %h/%b/%b",
               name, tx_data, grant, locked, d, g, lk);
    end
  endtask

  task automatic test_reset();
    rst = 1'b1;
    repeat (2) @(negedge clk);
    checks++;
    if ({req_ready, grant, locked, tx_write, tx_data} !== '0) begin
      failures++;
      $display("FAIL reset: ready/grant/locked/write/data got %b/%b/%b/%b/%h expected all 0",
               req_ready, grant, locked, tx_write, tx_data);
    end
    rst = 1'b0;
    @(negedge clk);
  endtask

  task automatic test_single();
    req_valid = 3'b010; req_data[15:8] = 8'h41; req_last = 3'b010;
    expect_write("single", 8'h41, 3'b010, 1'b0);
    checks++;
    if (req_ready !== 3'b010) begin
      failures++;
      $display("FAIL single_ready: got %b expected 010", req_ready);
    end
    req_valid = '0;
    @(negedge clk);
    checks++;
    if ({tx_write, req_ready, grant} !== {1'b0, 3'b000, 3'b010}) begin
      failures++;
      $display("FAIL single_pulse: write/ready/grant got %b/%b/%b expected 0/000/010",
               tx_write, req_ready, grant);
    end
    wait_quiet();
  endtask

  task automatic test_ptr();
    req_valid = 3'b101; req_data = 24'h0C_00_0A; req_last = 3'b111;
    expect_write("ptr_first", 8'h0C, 3'b100, 1'b0);
    req_valid = 3'b001;
    expect_write("ptr_wrap", 8'h0A, 3'b001, 1'b0);
    req_valid = '0;
    wait_quiet();
  endtask

  task automatic test_round_robin();
    logic [7:0] exp_d [5] = '{8'h20, 8'h30, 8'h10, 8'h20, 8'h30};
    logic [2:0] exp_g [5] = '{3'b010, 3'b100, 3'b001, 3'b010, 3'b100};
    req_valid = 3'b111; req_data = 24'h30_20_10; req_last = 3'b111;
    for (int i = 0; i < 5; i++) expect_write("round_robin", exp_d[i], exp_g[i], 1'b0);
    req_valid = '0;
    wait_quiet();
  endtask

  task automatic test_lock();
    req_valid = 3'b101; req_data = 24'h55_00_AA; req_last = 3'b100;
    expect_write("lock_aa", 8'hAA, 3'b001, 1'b1);
    req_data[7:0] = 8'hBB;
    expect_write("lock_bb", 8'hBB, 3'b001, 1'b1);
    req_data[7:0] = 8'hCC; req_last = 3'b101;
    expect_write("lock_cc", 8'hCC, 3'b001, 1'b0);
    req_valid = 3'b100;
    expect_write("lock_other", 8'h55, 3'b100, 1'b0);
    req_valid = '0;
    wait_quiet();
  endtask

  task automatic test_busy_stall();
    int hits = 0;
    busy_hold = 1'b1;
    req_valid = 3'b001; req_data[7:0] = 8'h5A; req_last = 3'b001;
    repeat (20) begin
      @(negedge clk);
      if (tx_write || req_ready != '0) hits++;
    end
    checks++;
    if (hits !== 0) begin
      failures++;
      $display("FAIL busy_stall: got %0d write/ready cycles expected 0", hits);
    end
    busy_hold = 1'b0;
    @(negedge clk);
    checks++;
    if ({tx_write, tx_data, req_ready} !== {1'b1, 8'h5A, 3'b001}) begin
      failures++;
      $display("FAIL busy_release: write/data/ready got %b/%h/%b expected 1/5a/001",
               tx_write, tx_data, req_ready);
    end
    req_valid = '0;
    wait_quiet();
  endtask

  task automatic test_reset_mid_frame();
    int early = 0;
    int extra = 0;
    req_valid = 3'b010; req_data[15:8] = 8'h7E; req_last = 3'b010;
    expect_write("pre_reset", 8'h7E, 3'b010, 1'b0);
    req_valid = '0;
    repeat (2) @(negedge clk);
    req_valid = 3'b100; req_data[23:16] = 8'h99; req_last = 3'b100;
    rst = 1'b1;
    #1;
    checks++;
    if ({req_ready, grant, locked, tx_write, tx_data} !== '0) begin
      failures++;
      $display("FAIL reset_async: ready/grant/locked/write/data got %b/%b/%b/%b/%h expected all 0",
               req_ready, grant, locked, tx_write, tx_data);
    end
    @(negedge clk);
    rst = 1'b0;
    for (int i = 0; i < 50 && tx_busy; i++) begin
      if (tx_write) early++;
      @(negedge clk);
    end
    checks++;
    if (early !== 0 || tx_busy !== 1'b0) begin
      failures++;
      $display("FAIL reset_hold: got %0d writes while busy (busy=%b) expected 0", early, tx_busy);
    end
    expect_write("post_reset", 8'h99, 3'b100, 1'b0);
    req_valid = '0;
    repeat (15) begin
      @(negedge clk);
      if (tx_write) extra++;
    end
    checks++;
    if (extra !== 0) begin
      failures++;
      $display("FAIL reset_once: got %0d extra writes expected 0", extra);
    end
  endtask

`ifdef UART_ARB_TIMEOUT_EN
  task automatic test_timeout();
    int n = 0;
    req_valid = 3'b011; req_data[15:0] = 16'h33_11; req_last = 3'b010;
    expect_write("timeout_lock", 8'h11, 3'b001, 1'b1);
    req_valid = 3'b010;
    for (int i = 1; i <= 40; i++) begin
      @(negedge clk);
      if (lock_timeout) begin
        n = i;
        break;
      end
    end
    checks++;
    if (n !== 14 || locked !== 1'b0) begin
      failures++;
      $display("FAIL timeout_pulse: cycles/locked got %0d/%b expected 14/0", n, locked);
    end
    @(negedge clk);
    checks++;
    if ({lock_timeout, tx_write, tx_data, grant} !== {1'b0, 1'b1, 8'h33, 3'b010}) begin
      failures++;
      $display("FAIL timeout_next: pulse/write/data/grant got %b/%b/%h/%b expected 0/1/33/010",
               lock_timeout, tx_write, tx_data, grant);
    end
    req_valid = '0;
    wait_quiet();
  endtask
`endif

  task automatic test_protocol();
    checks++;
    if (proto_err !== 0) begin
      failures++;
      $display("FAIL protocol: got %0d strobe/ready violations expected 0", proto_err);
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    @(negedge clk);
    test_reset();
    test_single();
    test_ptr();
    test_round_robin();
    test_lock();
    test_busy_stall();
    test_reset_mid_frame();
`ifdef UART_ARB_TIMEOUT_EN
    test_timeout();
`endif
    test_protocol();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
